// File: rtl/queue_count_ctrl.sv
// queue_count_ctrl
//   Produces the {pcount, tcount} address for the queue wait-time table.
//   pcount tracks customers from the raw entry/exit sensor levels
//   (synchronised, rising-edge detected, saturating at 2**CNT_W-1 and 0).
//   tcount holds the operator-loaded active-teller count (1..3, 0 rejected).
//   upd pulses for one cycle, aligned with the new values, whenever either
//   value changes.
//
//   Optional feature macro: QUEUE_ERR_STICKY_EN
//     Adds err_clr/err. err is a sticky flag set by a saturated entry, a
//     floored exit or a rejected teller load (t_val == 0); err_clr clears
//     it, with set winning over clear in the same cycle.
//
//   Sensor levels already high when rst deasserts must not count. Each
//   sensor therefore has an "armed" flag that is only set once a genuine
//   low sample has come through the synchroniser. The reset zeros inside
//   the synchroniser are not genuine samples, so a shared valid chain
//   marks when real samples reach the synchroniser output.

module queue_count_ctrl #(
   parameter int CNT_W       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int T_RESET     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sens_in,
   input  logic             sens_out,
   input  logic             t_load,
   input  logic [1:0]       t_val,
`ifdef QUEUE_ERR_STICKY_EN
   input  logic             err_clr,
   output logic             err,
`endif
   output logic [CNT_W-1:0] pcount,
   output logic [1:0]       tcount,
   output logic             full,
   output logic             empty,
   output logic             upd
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]       T_INIT  = 2'(T_RESET);

   // Synchroniser, valid, history and arm state
   logic [SYNC_STAGES-1:0] sync_in_q;
   logic [SYNC_STAGES-1:0] sync_out_q;
   logic [SYNC_STAGES-1:0] vld_q;
   logic                   hist_in_q;
   logic                   hist_out_q;
   logic                   arm_in_q;
   logic                   arm_out_q;

   logic                   synced_in;
   logic                   synced_out;
   logic                   smp_vld;
   logic                   inc;
   logic                   dec;

   // Counter and teller state
   logic [CNT_W-1:0]       pcount_q, pcount_d;
   logic [1:0]             tcount_q, tcount_d;
   logic                   full_q,   full_d;
   logic                   empty_q,  empty_d;
   logic                   upd_q,    upd_d;

   assign synced_in  = sync_in_q[SYNC_STAGES-1];
   assign synced_out = sync_out_q[SYNC_STAGES-1];
   assign smp_vld    = vld_q[SYNC_STAGES-1];

   // One count event per rising edge of an armed, synchronised sensor level
   assign inc = synced_in  & ~hist_in_q  & arm_in_q;
   assign dec = synced_out & ~hist_out_q & arm_out_q;

   // Sensor synchronisers, edge-detect history and arming after reset
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // the pre-edge values of the others, exactly like the hardware.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_in_q  <= '0;
         sync_out_q <= '0;
         vld_q      <= '0;
         hist_in_q  <= 1'b0;
         hist_out_q <= 1'b0;
         arm_in_q   <= 1'b0;
         arm_out_q  <= 1'b0;
      end else begin
         sync_in_q  <= {sync_in_q[SYNC_STAGES-2:0],  sens_in};
         sync_out_q <= {sync_out_q[SYNC_STAGES-2:0], sens_out};
         vld_q      <= {vld_q[SYNC_STAGES-2:0], 1'b1};
         hist_in_q  <= synced_in;
         hist_out_q <= synced_out;
         arm_in_q   <= arm_in_q  | (smp_vld & ~synced_in);
         arm_out_q  <= arm_out_q | (smp_vld & ~synced_out);
      end
   end

   // Next-state for people count, teller count, flags and update pulse
   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      pcount_d = pcount_q;
      tcount_d = tcount_q;

      case ({inc, dec})
         2'b10:   if (!full_q)  pcount_d = pcount_q + CNT_ONE;
         2'b01:   if (!empty_q) pcount_d = pcount_q - CNT_ONE;
         default: pcount_d = pcount_q;  // idle, or one in and one out
      endcase

      if (t_load && (t_val != 2'd0)) begin
         tcount_d = t_val;
      end

      full_d  = (pcount_d == CNT_MAX);
      empty_d = (pcount_d == '0);
      upd_d   = (pcount_d != pcount_q) || (tcount_d != tcount_q);
   end

   // Registered count, teller, flags and update pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcount_q <= '0;
         tcount_q <= T_INIT;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         upd_q    <= 1'b0;
      end else begin
         pcount_q <= pcount_d;
         tcount_q <= tcount_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         upd_q    <= upd_d;
      end
   end

   assign pcount = pcount_q;
   assign tcount = tcount_q;
   assign full   = full_q;
   assign empty  = empty_q;
   assign upd    = upd_q;

`ifdef QUEUE_ERR_STICKY_EN
   logic err_q;
   logic err_evt;

   assign err_evt = (inc & ~dec & full_q)
                  | (dec & ~inc & empty_q)
                  | (t_load & (t_val == 2'd0));

   // Sticky error flag: set has priority over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (err_evt) begin
         err_q <= 1'b1;
      end else if (err_clr) begin
         err_q <= 1'b0;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_queue_count_ctrl.sv
// Testbench for queue_count_ctrl (default parameters: CNT_W=3,
// SYNC_STAGES=2, T_RESET=1). Exercises the err/err_clr ports too when
// QUEUE_ERR_STICKY_EN is defined.
module tb_queue_count_ctrl;

   localparam int CNT_W = 3;

   typedef struct {
      logic             sin;
      logic             sout;
      logic             tl;
      logic [1:0]       tv;
      logic [CNT_W-1:0] pc;
      logic [1:0]       tc;
      logic             u;
      logic             e;
   } vec_t;

   typedef struct {
      logic [CNT_W-1:0] pc;
      logic [1:0]       tc;
      logic             u;
      logic             e;
   } exp_t;

   logic             clk;
   logic             rst;
   logic             sens_in;
   logic             sens_out;
   logic             t_load;
   logic [1:0]       t_val;
   logic [CNT_W-1:0] pcount;
   logic [1:0]       tcount;
   logic             full;
   logic             empty;
   logic             upd;
`ifdef QUEUE_ERR_STICKY_EN
   logic             err_clr;
   logic             err;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs[$];
   exp_t sb[$];

   queue_count_ctrl #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(2),
      .T_RESET    (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sens_in (sens_in),
      .sens_out(sens_out),
      .t_load  (t_load),
      .t_val   (t_val),
`ifdef QUEUE_ERR_STICKY_EN
      .err_clr (err_clr),
      .err     (err),
`endif
      .pcount  (pcount),
      .tcount  (tcount),
      .full    (full),
      .empty   (empty),
      .upd     (upd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic sin, input logic sout, input logic tl, input logic [1:0] tv,
                      input logic [CNT_W-1:0] pc, input logic [1:0] tc, input logic u, input logic e);
      vec_t v;
      v.sin = sin; v.sout = sout; v.tl = tl; v.tv = tv;
      v.pc = pc; v.tc = tc; v.u = u; v.e = e;
      vecs.push_back(v);
   endtask

   // Drive one cycle of stimulus, queue its expected result, compare after the edge
   task automatic step(input vec_t v, input string tag);
      exp_t x;
      exp_t got;
      sens_in  = v.sin;
      sens_out = v.sout;
      t_load   = v.tl;
      t_val    = v.tv;
      x.pc = v.pc; x.tc = v.tc; x.u = v.u; x.e = v.e;
      sb.push_back(x);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check({tag, " pcount"}, 32'(pcount), 32'(got.pc));
      check({tag, " tcount"}, 32'(tcount), 32'(got.tc));
      check({tag, " full"},   32'(full),   32'(got.pc == 3'd7));
      check({tag, " empty"},  32'(empty),  32'(got.pc == 3'd0));
      check({tag, " upd"},    32'(upd),    32'(got.u));
`ifdef QUEUE_ERR_STICKY_EN
      check({tag, " err"},    32'(err),    32'(got.e));
`endif
   endtask

   task automatic s(input logic sin, input logic sout, input logic tl, input logic [1:0] tv,
                    input logic [CNT_W-1:0] pc, input logic [1:0] tc, input logic u,
                    input logic e, input string tag);
      vec_t v;
      v.sin = sin; v.sout = sout; v.tl = tl; v.tv = tv;
      v.pc = pc; v.tc = tc; v.u = u; v.e = e;
      step(v, tag);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " pcount"}, 32'(pcount), 0);
      check({tag, " tcount"}, 32'(tcount), 1);
      check({tag, " empty"},  32'(empty),  1);
      check({tag, " full"},   32'(full),   0);
      check({tag, " upd"},    32'(upd),    0);
`ifdef QUEUE_ERR_STICKY_EN
      check({tag, " err"},    32'(err),    0);
`endif
   endtask

   initial begin
      // ---------------- vector table: sin sout tl tv | pc tc upd err
      // entry latency: level held 10 cycles, counted once, 2 edges after first sample
      add(1,0,0,0, 0,1,0,0);
      add(1,0,0,0, 0,1,0,0);
      add(1,0,0,0, 1,1,1,0);
      for (int i = 0; i < 7; i++) add(1,0,0,0, 1,1,0,0);
      for (int i = 0; i < 3; i++) add(0,0,0,0, 1,1,0,0);
      // eight more single-cycle entry pulses: climb to 7, then two saturate
      add(1,0,0,0, 1,1,0,0);  add(0,0,0,0, 1,1,0,0);
      add(1,0,0,0, 2,1,1,0);  add(0,0,0,0, 2,1,0,0);
      add(1,0,0,0, 3,1,1,0);  add(0,0,0,0, 3,1,0,0);
      add(1,0,0,0, 4,1,1,0);  add(0,0,0,0, 4,1,0,0);
      add(1,0,0,0, 5,1,1,0);  add(0,0,0,0, 5,1,0,0);
      add(1,0,0,0, 6,1,1,0);  add(0,0,0,0, 6,1,0,0);
      add(1,0,0,0, 7,1,1,0);  add(0,0,0,0, 7,1,0,0);
      add(1,0,0,0, 7,1,0,1);  add(0,0,0,0, 7,1,0,1);
      add(0,0,0,0, 7,1,0,1);  add(0,0,0,0, 7,1,0,1);
      // teller load: 3 accepted, 0 rejected, 3 again is a no-op
      add(0,0,1,3, 7,3,1,1);
      add(0,0,1,0, 7,3,0,1);
      add(0,0,1,3, 7,3,0,1);
      add(0,0,0,0, 7,3,0,1);
      // four exit pulses: 7 -> 3
      add(0,1,0,0, 7,3,0,1);  add(0,0,0,0, 7,3,0,1);
      add(0,1,0,0, 6,3,1,1);  add(0,0,0,0, 6,3,0,1);
      add(0,1,0,0, 5,3,1,1);  add(0,0,0,0, 5,3,0,1);
      add(0,1,0,0, 4,3,1,1);  add(0,0,0,0, 4,3,0,1);
      add(0,0,0,0, 3,3,1,1);  add(0,0,0,0, 3,3,0,1);
      // simultaneous entry and exit at pcount=3: no change, no upd
      add(1,1,0,0, 3,3,0,1);  add(0,0,0,0, 3,3,0,1);
      add(0,0,0,0, 3,3,0,1);  add(0,0,0,0, 3,3,0,1);
      // exits down to 0, then one more exit floors at 0
      add(0,1,0,0, 3,3,0,1);  add(0,0,0,0, 3,3,0,1);
      add(0,1,0,0, 2,3,1,1);  add(0,0,0,0, 2,3,0,1);
      add(0,1,0,0, 1,3,1,1);  add(0,0,0,0, 1,3,0,1);
      add(0,1,0,0, 0,3,1,1);  add(0,0,0,0, 0,3,0,1);
      add(0,0,0,0, 0,3,0,1);  add(0,0,0,0, 0,3,0,1);
      // entry landing on the same edge as a teller load: one upd
      add(1,0,0,0, 0,3,0,1);
      add(0,0,0,0, 0,3,0,1);
      add(0,0,1,2, 1,2,1,1);
      add(0,0,0,0, 1,2,0,1);

      // ---------------- power-on reset, checked before any clock edge
      rst = 1'b1; sens_in = 1'b0; sens_out = 1'b0; t_load = 1'b0; t_val = 2'd0;
`ifdef QUEUE_ERR_STICKY_EN
      err_clr = 1'b0;
`endif
      #2;
      check_reset_state("por");
      @(posedge clk);
      @(posedge clk);
      #4 rst = 1'b0;
      for (int i = 0; i < 4; i++) s(0,0,0,0, 0,1,0,0, "idle");

      // ---------------- table
      foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

`ifdef QUEUE_ERR_STICKY_EN
      // ---------------- sticky error: clear, set/clear collision, clear
      err_clr = 1'b1;
      s(0,0,0,0, 1,2,0,0, "err_clr");
      s(0,0,1,0, 1,2,0,1, "err_set_wins");
      s(0,0,0,0, 1,2,0,0, "err_clr2");
      err_clr = 1'b0;
`endif

      // ---------------- build pcount=5 with sens_in left high
      s(1,0,0,0, 1,2,0,0, "mid0");  s(0,0,0,0, 1,2,0,0, "mid1");
      s(1,0,0,0, 2,2,1,0, "mid2");  s(0,0,0,0, 2,2,0,0, "mid3");
      s(1,0,0,0, 3,2,1,0, "mid4");  s(0,0,0,0, 3,2,0,0, "mid5");
      s(1,0,0,0, 4,2,1,0, "mid6");  s(1,0,0,0, 4,2,0,0, "mid7");
      s(1,0,0,0, 5,2,1,0, "mid8");  s(1,0,0,0, 5,2,0,0, "mid9");
      s(1,0,0,0, 5,2,0,0, "mid10");

      // ---------------- asynchronous reset mid-cycle, sensor still high
      #2 rst = 1'b1;
      #1;
      check_reset_state("async_rst");
      @(posedge clk);
      #3 rst = 1'b0;
      for (int i = 0; i < 6; i++) s(1,0,0,0, 0,1,0,0, "held_after_rst");
      for (int i = 0; i < 3; i++) s(0,0,0,0, 0,1,0,0, "fall_after_rst");
      s(1,0,0,0, 0,1,0,0, "rerise0");
      s(1,0,0,0, 0,1,0,0, "rerise1");
      s(1,0,0,0, 1,1,1,0, "rerise2");
      s(0,0,0,0, 1,1,0,0, "rerise3");

      check("scoreboard drained", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
